// File: rtl/ooo_resp_pkg.sv
// rtl/ooo_resp_pkg.sv - shared types and constants for the out-of-order read responder
package ooo_resp_pkg;

    localparam int ID_W    = 4;
    localparam int NUM_IDS = 16;
    localparam int LAT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SENT
    } entry_state_e;

    // x^8 + x^6 + x^5 + x^4 + 1, taken from bits 7,5,4,3 of a left-shifting register
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ooo_resp_entry.sv
// rtl/ooo_resp_entry.sv - one per-ID outstanding-request entry with its latency counter
module ooo_resp_entry
    import ooo_resp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ar_hs,
    input  logic [LAT_W-1:0] i_lat,
    input  logic             i_load,
    input  logic             i_r_hs,
    output logic             o_busy,
    output logic             o_eligible
);

    entry_state_e     r_state;
    entry_state_e     w_state_nxt;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_ar_hs) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = i_lat;
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
                // the picker only selects entries whose counter has reached zero
                if (i_load) begin
                    w_state_nxt = SENT;
                end
            end
            SENT: begin
                if (i_r_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_busy     = (r_state != IDLE);
    assign o_eligible = (r_state == WAIT) && (r_cnt == '0);

endmodule

// File: rtl/axi_ooo_read_responder.sv
// rtl/axi_ooo_read_responder.sv - AXI-style read slave returning R beats out of order by ID latency
// Define OOO_RESP_LFSR_LAT_EN to draw latencies from an 8-bit LFSR instead of the ID formula.
module axi_ooo_read_responder
    import ooo_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LAT_BASE   = 2,
    parameter int LAT_STEP   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_W-1:0]       s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [ID_W-1:0]       s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i
);

    logic [NUM_IDS-1:0]    w_busy;
    logic [NUM_IDS-1:0]    w_elig;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_load;
    logic                  w_any;
    logic [ID_W-1:0]       w_pick;
    logic [LAT_W-1:0]      w_lat;

    logic                  r_rvalid;
    logic [ID_W-1:0]       r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;

    assign s_arready_o = !w_busy[s_arid_i];
    assign w_ar_hs     = s_arvalid_i && s_arready_o;
    assign w_r_hs      = r_rvalid && s_rready_i;
    // refilling on the handshake cycle keeps back-to-back beats without a bubble
    assign w_load      = !r_rvalid || s_rready_i;

`ifdef OOO_RESP_LFSR_LAT_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_ar_hs) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_lat = LAT_W'(LAT_BASE) + {4'b0000, r_lfsr[3:0]};
`else
    assign w_lat = LAT_W'(LAT_BASE)
                 + LAT_W'(LAT_STEP) * (LAT_W'(NUM_IDS - 1) - LAT_W'(s_arid_i));
`endif

    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any  = 1'b1;
                w_pick = ID_W'(i);
            end
        end
    end

    for (genvar g = 0; g < NUM_IDS; g++) begin : g_entry
        ooo_resp_entry u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_ar_hs    (w_ar_hs && (s_arid_i == ID_W'(g))),
            .i_lat      (w_lat),
            .i_load     (w_load && w_any && (w_pick == ID_W'(g))),
            .i_r_hs     (w_r_hs && (r_rid == ID_W'(g))),
            .o_busy     (w_busy[g]),
            .o_eligible (w_elig[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
        end else if (w_load) begin
            r_rvalid <= w_any;
            if (w_any) begin
                r_rid   <= w_pick;
                r_rdata <= {(DATA_WIDTH / 4){w_pick}};
            end
        end
    end

    assign s_rvalid_o = r_rvalid;
    assign s_rid_o    = r_rid;
    assign s_rdata_o  = r_rdata;

endmodule

// File: tb/tb_axi_ooo_read_responder.sv
// tb/tb_axi_ooo_read_responder.sv - scoreboard bench for the out-of-order read responder
module tb_axi_ooo_read_responder;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] arid    = 4'd0;
    logic       arvalid = 1'b0;
    logic       arready;
    logic [7:0] rdata;
    logic [3:0] rid;
    logic       rvalid;
    logic       rready  = 1'b0;

    always #5 clk = ~clk;

    axi_ooo_read_responder #(
        .DATA_WIDTH (8),
        .LAT_BASE   (2),
        .LAT_STEP   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_arid_i    (arid),
        .s_arvalid_i (arvalid),
        .s_arready_o (arready),
        .s_rdata_o   (rdata),
        .s_rid_o     (rid),
        .s_rvalid_o  (rvalid),
        .s_rready_i  (rready)
    );

    typedef struct {
        logic [3:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_beats  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [3:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rvalid && rready) begin
            n_beats++;
            if (sb.size() == 0) begin
                check("unexpected_beat", {28'd0, rid}, 32'hdead);
            end else begin
                e = sb.pop_front();
                check("rid", {28'd0, rid}, {28'd0, e.id});
                check("rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end
    end

    task automatic ar(input logic [3:0] id);
        arid    = id;
        arvalid = 1'b1;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rvalid && n < 100);
        if (!rvalid) check("rvalid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int b0;
        logic ok;

        #12;
        arid = 4'd0;
        #1 check("rst_arready_id0", {31'd0, arready}, 32'd1);
        arid = 4'd15;
        #1 check("rst_arready_id15", {31'd0, arready}, 32'd1);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rid", {28'd0, rid}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("post_rst_arready", {31'd0, arready}, 32'd1);

        // single request, id 15
        rready = 1'b1;
        push(4'd15, 8'hFF);
        ar(4'd15);
        wait_rvalid(n);
        check("lat_id15", n, 32'd3);
        @(posedge clk);
        #1 check("single_beat", {31'd0, rvalid}, 32'd0);

        // id 0 then id 15: 15 overtakes
        push(4'd15, 8'hFF);
        push(4'd0, 8'h00);
        ar(4'd0);
        ar(4'd15);
        wait_rvalid(n);
        check("ooo_first_lat", n, 32'd3);
        wait_rvalid(n);
        check("ooo_second_lat", n, 32'd14);
        @(posedge clk);
        #1;

        // backpressure on id 7
        rready = 1'b0;
        push(4'd7, 8'h77);
        ar(4'd7);
        wait_rvalid(n);
        check("lat_id7", n, 32'd11);
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!(rvalid && rid == 4'd7 && rdata == 8'h77)) ok = 1'b0;
        end
        check("bp_stable", {31'd0, ok}, 32'd1);
        rready = 1'b1;
        @(posedge clk);
        #1 check("bp_one_beat", {31'd0, rvalid}, 32'd0);

        // duplicate id 5 stalls until its R handshake
        rready = 1'b0;
        push(4'd5, 8'h55);
        push(4'd5, 8'h55);
        ar(4'd5);
        arid    = 4'd5;
        arvalid = 1'b1;
        #1 check("dup_stall", {31'd0, arready}, 32'd0);
        wait_rvalid(n);
        check("dup_stall_rvalid", {31'd0, arready}, 32'd0);
        rready = 1'b1;
        @(posedge clk);
        #1 check("dup_rearm", {31'd0, arready}, 32'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        check("dup_accepted", {31'd0, arready}, 32'd0);
        wait_rvalid(n);
        check("dup_lat", n, 32'd13);
        @(posedge clk);
        #1;

        // AR id 13 and R handshake of id 14 on the same edge
        rready = 1'b0;
        push(4'd14, 8'hEE);
        push(4'd13, 8'hDD);
        ar(4'd14);
        wait_rvalid(n);
        check("lat_id14", n, 32'd4);
        rready  = 1'b1;
        arid    = 4'd13;
        arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        check("concur_r_done", {31'd0, rvalid}, 32'd0);
        check("concur_ar_taken", {31'd0, arready}, 32'd0);
        wait_rvalid(n);
        check("lat_id13", n, 32'd5);
        @(posedge clk);
        #1;

        // fill all 16 entries
        rready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(4'(i), 8'(8'h11 * i));
            ar(4'(i));
        end
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            arid = 4'(i);
            #0.1;
            if (arready) ok = 1'b1;
        end
        check("all_busy_arready", {31'd0, ok}, 32'd0);
        rready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("all_drained", sb.size(), 32'd0);
        @(posedge clk);
        #1;

        // asynchronous reset with ids 1,2,3 in flight
        rready = 1'b0;
        ar(4'd1);
        ar(4'd2);
        ar(4'd3);
        wait_rvalid(n);
        check("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        #3 rst_n = 1'b0;
        #1 check("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
        sb.delete();
        #10;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rready = 1'b1;
        b0     = n_beats;
        repeat (40) @(posedge clk);
        #1 check("no_stale_beats", n_beats - b0, 32'd0);
        check("post_rst_arready_id1", {31'd0, arready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
